// File: rtl/coord_gen_pkg.sv
// Shared types and helpers for the pixel-coordinate stream generator.
//   state_t   : generator FSM states (IDLE, LOAD, RUN)
//   DEF_*     : default coordinate width / fractional bits (Q4.28)
//   to_fix()  : constant function, real -> two's complement fixed point
package coord_gen_pkg;

    localparam int unsigned DEF_COORD_W   = 32;
    localparam int unsigned DEF_FRAC_BITS = 28;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Scale by 2^frac and round; callers truncate to their coordinate width.
    function automatic logic [63:0] to_fix(input real v, input int unsigned frac);
        real scale;
        scale = 1.0;
        for (int unsigned i = 0; i < frac; i++) begin
            scale = scale * 2.0;
        end
        return 64'(longint'(v * scale));
    endfunction

endpackage

// File: rtl/coord_raster_counter.sv
// Raster position counter: x steps by NUM_LANES across a line, y steps per line.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   clear          return to (0,0) at frame start
//   advance        move to the next beat position
//   x, y           current beat position (x of lane 0, line index)
//   last_x_c       current beat is the last of its line
//   last_frame_c   current beat is the last of the frame
module coord_raster_counter #(
    parameter int unsigned X_SIZE    = 640,
    parameter int unsigned Y_SIZE    = 480,
    parameter int unsigned NUM_LANES = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        advance,
    output logic [$clog2(X_SIZE)-1:0]   x,
    output logic [$clog2(Y_SIZE)-1:0]   y,
    output logic                        last_x_c,
    output logic                        last_frame_c
);

    localparam int unsigned XW = $clog2(X_SIZE);
    localparam int unsigned YW = $clog2(Y_SIZE);
    localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - NUM_LANES);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

    assign last_x_c     = (x == X_LAST);
    assign last_frame_c = last_x_c && (y == Y_LAST);

    // Position registers; the final beat of a frame wraps back to (0,0).
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (last_x_c) begin
                x <= '0;
                y <= last_frame_c ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(NUM_LANES);
            end
        end
    end

endmodule

// File: rtl/coord_stream_gen.sv
// Pixel-coordinate source for the fractal pipeline: rasters X_SIZE x Y_SIZE,
// NUM_LANES pixels per beat, emitting screen (x,y) and plane (cr,ci) over a
// valid/ready stream. Viewport (x0, y0, step) is shadowed and applied per frame.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   run                  level, keep generating frames
//   cfg_wr, cfg_x0/y0/step  shadow viewport write
//   ready_next_stage     downstream accept
//   valid_out, x, y, cr, ci  beat payload (cr lane k at [k*COORD_W +: COORD_W])
//   frame_done           pulse after the last beat of a frame is accepted
//   busy                 FSM not idle
// Optional: define COORD_GEN_MARKERS_EN to add sof / eol beat markers.
module coord_stream_gen
    import coord_gen_pkg::*;
#(
    parameter int unsigned X_SIZE    = 640,
    parameter int unsigned Y_SIZE    = 480,
    parameter int unsigned NUM_LANES = 1,
    parameter int unsigned COORD_W   = DEF_COORD_W,
    parameter int unsigned FRAC_BITS = DEF_FRAC_BITS
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             run,
    input  logic                             cfg_wr,
    input  logic [COORD_W-1:0]               cfg_x0,
    input  logic [COORD_W-1:0]               cfg_y0,
    input  logic [COORD_W-1:0]               cfg_step,
    input  logic                             ready_next_stage,
    output logic                             valid_out,
    output logic [$clog2(X_SIZE)-1:0]        x,
    output logic [$clog2(Y_SIZE)-1:0]        y,
    output logic [NUM_LANES*COORD_W-1:0]     cr,
    output logic [COORD_W-1:0]               ci,
    output logic                             frame_done,
`ifdef COORD_GEN_MARKERS_EN
    output logic                             sof,
    output logic                             eol,
`endif
    output logic                             busy
);

    localparam int unsigned LANE_SHIFT = $clog2(NUM_LANES);

    if ((X_SIZE % NUM_LANES) != 0) begin : g_bad_lanes
        $error("X_SIZE must be a multiple of NUM_LANES");
    end
    if ((1 << LANE_SHIFT) != NUM_LANES) begin : g_bad_pow2
        $error("NUM_LANES must be a power of two");
    end
    if (FRAC_BITS >= COORD_W) begin : g_bad_frac
        $error("FRAC_BITS must be smaller than COORD_W");
    end

    state_t state;
    state_t next_state;

    logic [COORD_W-1:0]           sh_x0;
    logic [COORD_W-1:0]           sh_y0;
    logic [COORD_W-1:0]           sh_step;
    logic [COORD_W-1:0]           act_step;
    logic [NUM_LANES*COORD_W-1:0] act_base;
    logic [NUM_LANES*COORD_W-1:0] load_base_c;
    logic [COORD_W-1:0]           lane_inc_c;

    logic accept_c;
    logic load_c;
    logic advance_c;
    logic finish_c;
    logic last_x_c;
    logic last_frame_c;

    assign accept_c   = valid_out && ready_next_stage;
    assign lane_inc_c = act_step << LANE_SHIFT;

    // Lane start values x0 + k*step as a running sum over the shadow viewport.
    always_comb begin
        logic [COORD_W-1:0] acc;
        load_base_c = '0;
        acc         = sh_x0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            load_base_c[k*COORD_W +: COORD_W] = acc;
            acc = acc + sh_step;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (run) next_state = ST_LOAD;
            ST_LOAD: next_state = ST_RUN;
            ST_RUN:  if (accept_c && last_frame_c) next_state = run ? ST_LOAD : ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Control strobes
    always_comb begin
        load_c    = 1'b0;
        advance_c = 1'b0;
        finish_c  = 1'b0;
        case (state)
            ST_LOAD: load_c = 1'b1;
            ST_RUN: begin
                advance_c = accept_c;
                finish_c  = accept_c && last_frame_c;
            end
            default: ;
        endcase
    end

    coord_raster_counter #(
        .X_SIZE    (X_SIZE),
        .Y_SIZE    (Y_SIZE),
        .NUM_LANES (NUM_LANES)
    ) u_raster (
        .clk          (clk),
        .reset        (reset),
        .clear        (load_c),
        .advance      (advance_c),
        .x            (x),
        .y            (y),
        .last_x_c     (last_x_c),
        .last_frame_c (last_frame_c)
    );

    // Viewport shadow/active registers and the beat datapath.
    // A cfg_wr during LOAD lands in the shadow after the active copy is taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_x0      <= '0;
            sh_y0      <= '0;
            sh_step    <= '0;
            act_step   <= '0;
            act_base   <= '0;
            cr         <= '0;
            ci         <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_done <= finish_c;
            busy       <= (next_state != ST_IDLE);
            if (cfg_wr) begin
                sh_x0   <= cfg_x0;
                sh_y0   <= cfg_y0;
                sh_step <= cfg_step;
            end
            if (load_c) begin
                act_step  <= sh_step;
                act_base  <= load_base_c;
                cr        <= load_base_c;
                ci        <= sh_y0;
                valid_out <= 1'b1;
            end else if (advance_c) begin
                if (last_frame_c) begin
                    valid_out <= 1'b0;
                end else if (last_x_c) begin
                    cr <= act_base;
                    ci <= ci - act_step;
                end else begin
                    for (int unsigned k = 0; k < NUM_LANES; k++) begin
                        cr[k*COORD_W +: COORD_W] <= cr[k*COORD_W +: COORD_W] + lane_inc_c;
                    end
                end
            end
        end
    end

`ifdef COORD_GEN_MARKERS_EN
    // Markers describe the beat currently presented, so they move with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            sof <= 1'b0;
            eol <= 1'b0;
        end else if (load_c) begin
            sof <= 1'b1;
            eol <= (X_SIZE == NUM_LANES);
        end else if (advance_c) begin
            sof <= 1'b0;
            if (last_frame_c) begin
                eol <= 1'b0;
            end else if (last_x_c) begin
                eol <= (X_SIZE == NUM_LANES);
            end else begin
                eol <= ((32'(x) + NUM_LANES) == (X_SIZE - NUM_LANES));
            end
        end
    end
`endif

endmodule

// File: tb/tb_coord_stream_gen.sv
// Scoreboard bench for coord_stream_gen (16x4 frame, 4 lanes, Q4.28).
module tb_coord_stream_gen;
    import coord_gen_pkg::*;

    localparam int unsigned XS    = 16;
    localparam int unsigned YS    = 4;
    localparam int unsigned NL    = 4;
    localparam int unsigned CW    = 32;
    localparam int unsigned FB    = 28;
    localparam int unsigned BPL   = XS / NL;
    localparam int unsigned BEATS = XS * YS / NL;

    logic clk = 1'b0;
    logic reset, run, cfg_wr, ready;
    logic [CW-1:0] cfg_x0, cfg_y0, cfg_step;
    logic valid_out, frame_done, busy;
    logic [3:0] x;
    logic [1:0] y;
    logic [NL*CW-1:0] cr;
    logic [CW-1:0] ci;
`ifdef COORD_GEN_MARKERS_EN
    logic sof, eol;
`endif

    coord_stream_gen #(
        .X_SIZE(XS), .Y_SIZE(YS), .NUM_LANES(NL), .COORD_W(CW), .FRAC_BITS(FB)
    ) dut (
        .clk(clk), .reset(reset), .run(run), .cfg_wr(cfg_wr),
        .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_step(cfg_step),
        .ready_next_stage(ready), .valid_out(valid_out), .x(x), .y(y),
        .cr(cr), .ci(ci), .frame_done(frame_done),
`ifdef COORD_GEN_MARKERS_EN
        .sof(sof), .eol(eol),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned      bx;
        int unsigned      by;
        int unsigned      idx;
        logic [NL*CW-1:0] cr;
        logic [CW-1:0]    ci;
    } beat_t;

    beat_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned in_frame = 0;
    int unsigned frames_done = 0;
    logic        hold_ready = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference frame: every pixel computed directly from the viewport.
    task automatic push_frame(input logic [CW-1:0] x0, input logic [CW-1:0] y0,
                              input logic [CW-1:0] st);
        beat_t b;
        for (int unsigned yy = 0; yy < YS; yy++) begin
            for (int unsigned xx = 0; xx < XS; xx += NL) begin
                b.bx  = xx;
                b.by  = yy;
                b.idx = yy * BPL + xx / NL;
                for (int unsigned k = 0; k < NL; k++) begin
                    b.cr[k*CW +: CW] = x0 + CW'(xx + k) * st;
                end
                b.ci = y0 - CW'(yy) * st;
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic write_cfg(input logic [CW-1:0] x0, input logic [CW-1:0] y0,
                             input logic [CW-1:0] st);
        cfg_wr = 1'b1; cfg_x0 = x0; cfg_y0 = y0; cfg_step = st;
        @(posedge clk); #1;
        cfg_wr = 1'b0;
    endtask

    // Bounded wait until `frames` frames are done and `beats` of the next accepted.
    task automatic wait_progress(input int unsigned frames, input int unsigned beats,
                                 input string name);
        logic reached;
        reached = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (frames_done > frames || (frames_done == frames && in_frame >= beats)) begin
                reached = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk(name, 128'(reached), 128'(1));
    endtask

    // Random downstream backpressure.
    initial begin
        ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: pops the scoreboard on every accepted beat.
    logic             prev_stall = 1'b0;
    logic             expect_done = 1'b0;
    logic [3:0]       px;
    logic [1:0]       py;
    logic [NL*CW-1:0] pcr;
    logic [CW-1:0]    pci;

    always @(negedge clk) begin
        beat_t b;
        if (reset) begin
            prev_stall  = 1'b0;
            expect_done = 1'b0;
            in_frame    = 0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 128'(valid_out), 128'(1));
                chk("stall_x", 128'(x), 128'(px));
                chk("stall_y", 128'(y), 128'(py));
                chk("stall_cr", 128'(cr), 128'(pcr));
                chk("stall_ci", 128'(ci), 128'(pci));
            end
            chk("frame_done_timing", 128'(frame_done), 128'(expect_done));
            if (frame_done) begin
                frames_done++;
                in_frame = 0;
            end
            expect_done = 1'b0;
            if (valid_out && ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=x%0d,y%0d required=no beat", x, y);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_x", 128'(x), 128'(b.bx));
                    chk("beat_y", 128'(y), 128'(b.by));
                    chk("beat_cr", 128'(cr), 128'(b.cr));
                    chk("beat_ci", 128'(ci), 128'(b.ci));
`ifdef COORD_GEN_MARKERS_EN
                    chk("beat_sof", 128'(sof), 128'(b.idx == 0));
                    chk("beat_eol", 128'(eol), 128'(b.bx == XS - NL));
`endif
                end
                in_frame++;
                if (in_frame == BEATS) expect_done = 1'b1;
            end
            prev_stall = valid_out && !ready;
            px = x; py = y; pcr = cr; pci = ci;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0] vx0, vy0, vst, rx0, ry0, rst;
        reset = 1'b1; run = 1'b0; cfg_wr = 1'b0;
        cfg_x0 = '0; cfg_y0 = '0; cfg_step = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_valid", 128'(valid_out), 128'(0));
        chk("reset_x", 128'(x), 128'(0));
        chk("reset_y", 128'(y), 128'(0));
        chk("reset_cr", 128'(cr), 128'(0));
        chk("reset_ci", 128'(ci), 128'(0));
        chk("reset_frame_done", 128'(frame_done), 128'(0));
        chk("reset_busy", 128'(busy), 128'(0));

        // Frame 1: x0=-2.0, y0=1.0, step=1/256
        vx0 = CW'(to_fix(-2.0, FB));
        vy0 = CW'(to_fix(1.0, FB));
        vst = CW'(to_fix(1.0 / 256.0, FB));
        write_cfg(vx0, vy0, vst);
        push_frame(vx0, vy0, vst);
        run = 1'b1;
        @(posedge clk); #1;
        chk("lat1_valid", 128'(valid_out), 128'(0));
        chk("lat1_busy", 128'(busy), 128'(1));
        @(posedge clk); #1;
        chk("lat2_valid", 128'(valid_out), 128'(1));
        chk("first_cr_lane0", 128'(cr[31:0]), 128'(32'hE000_0000));
        chk("first_cr_lane1", 128'(cr[63:32]), 128'(32'hE010_0000));
        chk("first_ci", 128'(ci), 128'(32'h1000_0000));

        // Mid-frame viewport change only affects the following frame.
        wait_progress(0, 5, "wait_f1_mid");
        write_cfg('0, vy0, vst);
        push_frame('0, vy0, vst);

        // Drop run during frame 2: it still completes, then idle.
        wait_progress(1, 3, "wait_f2_mid");
        run = 1'b0;
        wait_progress(2, 0, "wait_f2_done");
        repeat (4) @(posedge clk);
        #1;
        chk("idle_busy", 128'(busy), 128'(0));
        chk("idle_valid", 128'(valid_out), 128'(0));
        chk("frames_after_run_drop", 128'(frames_done), 128'(2));

        // Frame 3 with a random viewport, aborted by reset while stalled.
        rx0 = $urandom; ry0 = $urandom; rst = $urandom;
        write_cfg(rx0, ry0, rst);
        push_frame(rx0, ry0, rst);
        run = 1'b1;
        wait_progress(2, 5, "wait_f3_mid");
        hold_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_stalled_valid", 128'(valid_out), 128'(1));
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_valid", 128'(valid_out), 128'(0));
        chk("abort_x", 128'(x), 128'(0));
        chk("abort_y", 128'(y), 128'(0));
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_cr", 128'(cr), 128'(0));
        chk("abort_ci", 128'(ci), 128'(0));
        exp_q.delete();
        run = 1'b0;
        hold_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;

        // Frame 4: shadow was cleared by reset, so every coordinate is zero.
        push_frame('0, '0, '0);
        run = 1'b1;
        wait_progress(2, 2, "wait_f4_mid");
        run = 1'b0;
        wait_progress(3, 0, "wait_f4_done");

        // Frames 5-6: back-to-back with a random wrapping viewport.
        rx0 = $urandom; ry0 = $urandom; rst = $urandom;
        write_cfg(rx0, ry0, rst);
        push_frame(rx0, ry0, rst);
        push_frame(rx0, ry0, rst);
        run = 1'b1;
        wait_progress(4, 3, "wait_f6_mid");
        run = 1'b0;
        wait_progress(5, 0, "wait_f6_done");
        repeat (5) @(posedge clk);
        #1;
        chk("queue_empty", 128'(exp_q.size()), 128'(0));
        chk("frames_total", 128'(frames_done), 128'(5));
        chk("final_busy", 128'(busy), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
